// File: rtl/winocnn_pkg.sv
// Shared types and constants for the Winograd CNN scheduling blocks.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package winocnn_pkg;

    localparam int TILE_DIM   = 6;
    localparam int STRIDE_1X1 = 6;
    localparam int STRIDE_3X3 = 4;

    localparam int IDX_W = 9;
    localparam int OD_W  = 8;
    localparam int ID_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    // Tile stride in pixels: 1x1 kernels consume a full 6x6 tile, 3x3 kernels
    // overlap neighbouring tiles by two pixels.
    function automatic logic [3:0] stride_of(input logic size_type);
        return size_type ? 4'(STRIDE_3X3) : 4'(STRIDE_1X1);
    endfunction

endpackage

// File: rtl/pe_array_scheduler_if.sv
// Request bundle from the scheduler to the input- and weight-transform stages.
// Latency: n/a (wires only).
// Backpressure: each request has its own valid/ready pair.
// Signals:
//   data_req_*   : one data tile per PE column, shared y and input channel
//   weight_req_* : one weight tile per PE row, shared input channel
interface pe_array_scheduler_if #(
    parameter int N_ROW = 4,
    parameter int N_COL = 4
);
    import winocnn_pkg::*;

    logic                             data_req_valid;
    logic                             data_req_ready;
    logic [N_COL-1:0][IDX_W-1:0]      data_req_x;
    logic [IDX_W-1:0]                 data_req_y;
    logic [ID_W-1:0]                  data_req_id;
    logic [N_COL-1:0]                 data_req_mask;

    logic                             weight_req_valid;
    logic                             weight_req_ready;
    logic [N_ROW-1:0][OD_W-1:0]       weight_req_od;
    logic [ID_W-1:0]                  weight_req_id;
    logic [N_ROW-1:0]                 weight_req_mask;

    modport master (
        output data_req_valid, data_req_x, data_req_y, data_req_id, data_req_mask,
        input  data_req_ready,
        output weight_req_valid, weight_req_od, weight_req_id, weight_req_mask,
        input  weight_req_ready
    );

    modport slave (
        input  data_req_valid, data_req_x, data_req_y, data_req_id, data_req_mask,
        output data_req_ready,
        input  weight_req_valid, weight_req_od, weight_req_id, weight_req_mask,
        output weight_req_ready
    );

endinterface

// File: rtl/pe_array_scheduler_launch_skew.sv
// One-bit token shift line producing systolically skewed launch strobes.
// Latency: tap k is token_in delayed k+1 cycles.
// Backpressure: none; free-running shift.
// Ports: clk, reset (async, active-high), token_in, taps[LANES-1:0].
module launch_skew #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             token_in,
    output logic [LANES-1:0] taps
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps <= '0;
        end else begin
            // Shift toward the far lane; the oldest token falls off the end.
            taps <= LANES'({taps, token_in});
        end
    end

endmodule

// File: rtl/pe_array_scheduler.sv
// Walks id/od/x/y loops of a Winograd layer, issuing paired data/weight tile requests and skewed launches.
// Latency: first request 1 cycle after start; launches start 1 cycle after each pass; done N_ROW+N_COL+1 after last pass.
// Backpressure: each request valid holds until its ready; the next pass waits for both accepts.
// Ports: clk, reset; cfg_* layer config (latched on start); busy/done status;
//        req (interface master) carries both request handshakes; col_launch/row_launch edge strobes.
module pe_array_scheduler
    import winocnn_pkg::*;
#(
    parameter int N_ROW = 4,
    parameter int N_COL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [IDX_W-1:0]  cfg_img_h,
    input  logic [IDX_W-1:0]  cfg_img_w,
    input  logic [OD_W-1:0]   cfg_od,
    input  logic [ID_W-1:0]   cfg_id_m1,
    input  logic              cfg_size_type,
    output logic              busy,
    output logic              done,
    output logic              weight_size_type_o,
    output logic [N_COL-1:0]  col_launch,
    output logic [N_ROW-1:0]  row_launch,
    pe_array_scheduler_if.master req
);

    localparam int XW        = IDX_W + 1;   // x/y compare width, never wraps
    localparam int OW        = OD_W + 1;    // od compare width
    localparam int DRAIN_CYC = N_ROW + N_COL;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    sched_state_t       state;
    logic [IDX_W-1:0]   img_h_r, img_w_r;
    logic [OD_W-1:0]    od_r;
    logic [ID_W-1:0]    id_m1_r;
    logic               size_type_r;

    logic [IDX_W-1:0]   x_base, y_cnt;
    logic [OD_W-1:0]    od_base;
    logic [ID_W-1:0]    id_cnt;
    logic [DW-1:0]      drain_cnt;

    // Loop bookkeeping
    logic [XW-1:0]      stride, x_step, x_sum, y_sum;
    logic [OW-1:0]      od_sum;
    logic               id_wrap, od_wrap, x_wrap, y_wrap, last_pass;
    logic               data_acc, wt_acc, pass_done, cfg_zero, load_pass;

    logic [IDX_W-1:0]   nxt_x, nxt_y;
    logic [OD_W-1:0]    nxt_od;
    logic [ID_W-1:0]    nxt_id;

    // Values for the pass about to be loaded (first pass from cfg, later ones from counters)
    logic [IDX_W-1:0]   ld_x, ld_y, ld_img_w;
    logic [OD_W-1:0]    ld_od_base, ld_od;
    logic [ID_W-1:0]    ld_id;
    logic [XW-1:0]      ld_stride;
    logic [N_COL-1:0][IDX_W-1:0] ld_xv;
    logic [N_COL-1:0]   ld_xmask;
    logic [N_ROW-1:0][OD_W-1:0]  ld_odv;
    logic [N_ROW-1:0]   ld_odmask;

    assign stride  = XW'(stride_of(size_type_r));
    assign x_step  = stride * XW'(N_COL);
    assign x_sum   = {1'b0, x_base} + x_step;
    assign y_sum   = {1'b0, y_cnt} + stride;
    assign od_sum  = {1'b0, od_base} + OW'(N_ROW);

    assign id_wrap   = (id_cnt == id_m1_r);
    assign od_wrap   = (od_sum >= {1'b0, od_r});
    assign x_wrap    = (x_sum >= {1'b0, img_w_r});
    assign y_wrap    = (y_sum >= {1'b0, img_h_r});
    assign last_pass = id_wrap & od_wrap & x_wrap & y_wrap;

    assign data_acc  = req.data_req_valid & req.data_req_ready;
    assign wt_acc    = req.weight_req_valid & req.weight_req_ready;
    // A side already accepted earlier in the pass has its valid low and counts as finished.
    assign pass_done = (state == ISSUE) & (data_acc | ~req.data_req_valid)
                                        & (wt_acc | ~req.weight_req_valid);
    assign cfg_zero  = (cfg_img_h == '0) | (cfg_img_w == '0) | (cfg_od == '0);
    assign load_pass = ((state == IDLE) & cfg_start & ~cfg_zero) | (pass_done & ~last_pass);

    // Counter advance, id innermost then od, x, y.
    always_comb begin
        nxt_id = id_cnt + ID_W'(1);
        nxt_od = od_base;
        nxt_x  = x_base;
        nxt_y  = y_cnt;
        if (id_wrap) begin
            nxt_id = '0;
            nxt_od = od_sum[OD_W-1:0];
            if (od_wrap) begin
                nxt_od = '0;
                nxt_x  = x_sum[IDX_W-1:0];
                if (x_wrap) begin
                    nxt_x = '0;
                    nxt_y = y_sum[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        logic [XW-1:0] xc;
        logic [OW-1:0] odr;
        xc  = '0;
        odr = '0;
        if (state == IDLE) begin
            ld_x = '0; ld_y = '0; ld_od_base = '0; ld_id = '0;
            ld_stride = XW'(stride_of(cfg_size_type));
            ld_img_w  = cfg_img_w;
            ld_od     = cfg_od;
        end else begin
            ld_x = nxt_x; ld_y = nxt_y; ld_od_base = nxt_od; ld_id = nxt_id;
            ld_stride = stride;
            ld_img_w  = img_w_r;
            ld_od     = od_r;
        end
        for (int c = 0; c < N_COL; c++) begin
            xc          = {1'b0, ld_x} + XW'(c) * ld_stride;
            ld_xmask[c] = (xc < {1'b0, ld_img_w});
            ld_xv[c]    = ld_xmask[c] ? xc[IDX_W-1:0] : '0;
        end
        for (int r = 0; r < N_ROW; r++) begin
            odr          = {1'b0, ld_od_base} + OW'(r);
            ld_odmask[r] = (odr < {1'b0, ld_od});
            ld_odv[r]    = ld_odmask[r] ? odr[OD_W-1:0] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            img_h_r               <= '0;
            img_w_r               <= '0;
            od_r                  <= '0;
            id_m1_r               <= '0;
            size_type_r           <= 1'b0;
            x_base                <= '0;
            y_cnt                 <= '0;
            od_base               <= '0;
            id_cnt                <= '0;
            drain_cnt             <= '0;
            req.data_req_valid    <= 1'b0;
            req.data_req_x        <= '0;
            req.data_req_y        <= '0;
            req.data_req_id       <= '0;
            req.data_req_mask     <= '0;
            req.weight_req_valid  <= 1'b0;
            req.weight_req_od     <= '0;
            req.weight_req_id     <= '0;
            req.weight_req_mask   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        img_h_r     <= cfg_img_h;
                        img_w_r     <= cfg_img_w;
                        od_r        <= cfg_od;
                        id_m1_r     <= cfg_id_m1;
                        size_type_r <= cfg_size_type;
                        busy        <= 1'b1;
                        if (cfg_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state                <= ISSUE;
                            req.data_req_valid   <= 1'b1;
                            req.weight_req_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (data_acc) req.data_req_valid   <= 1'b0;
                    if (wt_acc)   req.weight_req_valid <= 1'b0;
                    if (pass_done) begin
                        if (last_pass) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            req.data_req_valid   <= 1'b1;
                            req.weight_req_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Lets the last skewed launches clear the array edge before done.
                    if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (load_pass) begin
                x_base               <= ld_x;
                y_cnt                <= ld_y;
                od_base              <= ld_od_base;
                id_cnt               <= ld_id;
                req.data_req_x       <= ld_xv;
                req.data_req_mask    <= ld_xmask;
                req.data_req_y       <= ld_y;
                req.data_req_id      <= ld_id;
                req.weight_req_od    <= ld_odv;
                req.weight_req_mask  <= ld_odmask;
                req.weight_req_id    <= ld_id;
            end
        end
    end

    assign weight_size_type_o = size_type_r;

    launch_skew #(.LANES(N_COL)) u_col_skew (
        .clk      (clk),
        .reset    (reset),
        .token_in (pass_done),
        .taps     (col_launch)
    );

    launch_skew #(.LANES(N_ROW)) u_row_skew (
        .clk      (clk),
        .reset    (reset),
        .token_in (pass_done),
        .taps     (row_launch)
    );

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Self-checking bench for pe_array_scheduler against a loop-level reference model.
// Latency: n/a.
// Backpressure: readys are driven randomly or held low for directed windows.
module tb_pe_array_scheduler;

    localparam int NR = 4;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [8:0]  cfg_img_h, cfg_img_w;
    logic [7:0]  cfg_od;
    logic [3:0]  cfg_id_m1;
    logic        cfg_size_type;
    logic        busy, done, weight_size_type_o;
    logic [NC-1:0] col_launch;
    logic [NR-1:0] row_launch;

    pe_array_scheduler_if #(.N_ROW(NR), .N_COL(NC)) rq ();

    pe_array_scheduler #(.N_ROW(NR), .N_COL(NC)) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_start          (cfg_start),
        .cfg_img_h          (cfg_img_h),
        .cfg_img_w          (cfg_img_w),
        .cfg_od             (cfg_od),
        .cfg_id_m1          (cfg_id_m1),
        .cfg_size_type      (cfg_size_type),
        .busy               (busy),
        .done               (done),
        .weight_size_type_o (weight_size_type_o),
        .col_launch         (col_launch),
        .row_launch         (row_launch),
        .req                (rq.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int xb;
        int y;
        int ob;
        int id;
    } pass_t;

    bit [3:0] exp_col [int];
    bit [3:0] exp_row [int];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_done"},  64'(done), 64'(0));
        chk({tag, "_dvld"},  64'(rq.data_req_valid), 64'(0));
        chk({tag, "_wvld"},  64'(rq.weight_req_valid), 64'(0));
        chk({tag, "_dx"},    64'(rq.data_req_x), 64'(0));
        chk({tag, "_dy"},    64'(rq.data_req_y), 64'(0));
        chk({tag, "_did"},   64'(rq.data_req_id), 64'(0));
        chk({tag, "_dmask"}, 64'(rq.data_req_mask), 64'(0));
        chk({tag, "_wod"},   64'(rq.weight_req_od), 64'(0));
        chk({tag, "_wid"},   64'(rq.weight_req_id), 64'(0));
        chk({tag, "_wmask"}, 64'(rq.weight_req_mask), 64'(0));
        chk({tag, "_stype"}, 64'(weight_size_type_o), 64'(0));
        chk({tag, "_col"},   64'(col_launch), 64'(0));
        chk({tag, "_row"},   64'(row_launch), 64'(0));
    endtask

    // Runs one layer from a start pulse to one idle cycle after done.
    // d_hold: data ready forced low in cycles 1..d_hold.
    // restart_cyc: cycle with an extra (ignored) start pulse and altered config.
    // abort_cyc: cycle after whose checks reset is asserted mid-layer.
    task automatic run_layer(input int h, input int w, input int od, input int idm1,
                             input int st, input int rdy_pct, input int d_hold,
                             input int restart_cyc, input int abort_cyc);
        pass_t q[$];
        pass_t p;
        int s, t_done, bound, xc, oc;
        bit got_d, got_w, finished, issuing;
        logic [NC-1:0][8:0] ex;
        logic [NC-1:0]      exm;
        logic [NR-1:0][7:0] eo;
        logic [NR-1:0]      eom;

        s = st ? 4 : 6;
        for (int y = 0; y < h; y += s)
            for (int xb = 0; xb < w; xb += s * NC)
                for (int ob = 0; ob < od; ob += NR)
                    for (int id = 0; id <= idm1; id++) begin
                        p.xb = xb; p.y = y; p.ob = ob; p.id = id;
                        q.push_back(p);
                    end
        t_done = (q.size() == 0) ? 1 : -1;
        bound  = 30 + q.size() * 60;
        exp_col.delete();
        exp_row.delete();
        got_d = 0; got_w = 0; finished = 0;

        for (int cyc = 0; cyc < bound; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                cfg_start     = 1'b1;
                cfg_img_h     = 9'(h);
                cfg_img_w     = 9'(w);
                cfg_od        = 8'(od);
                cfg_id_m1     = 4'(idm1);
                cfg_size_type = st[0];
            end else begin
                // Config must have been latched: scramble it from here on.
                cfg_start     = (cyc == restart_cyc);
                cfg_img_h     = 9'($urandom);
                cfg_img_w     = (cyc == restart_cyc) ? 9'(w + 100) : 9'($urandom);
                cfg_od        = 8'($urandom);
                cfg_id_m1     = 4'($urandom);
                cfg_size_type = 1'($urandom);
            end
            rq.data_req_ready   = (cyc > d_hold) && ($urandom_range(99) < rdy_pct);
            rq.weight_req_ready = ($urandom_range(99) < rdy_pct);

            @(negedge clk);
            issuing = (cyc >= 1) && (q.size() > 0);
            chk("busy", 64'(busy), 64'(cyc >= 1 && (t_done < 0 || cyc <= t_done)));
            chk("done", 64'(done), 64'(cyc == t_done));
            chk("data_valid",   64'(rq.data_req_valid),   64'(issuing && !got_d));
            chk("weight_valid", 64'(rq.weight_req_valid), 64'(issuing && !got_w));
            chk("col_launch", 64'(col_launch), 64'(exp_col.exists(cyc) ? exp_col[cyc] : 4'd0));
            chk("row_launch", 64'(row_launch), 64'(exp_row.exists(cyc) ? exp_row[cyc] : 4'd0));
            if (cyc >= 1) chk("size_type", 64'(weight_size_type_o), 64'(st));

            if (issuing) begin
                for (int c = 0; c < NC; c++) begin
                    xc     = q[0].xb + c * s;
                    exm[c] = (xc < w);
                    ex[c]  = exm[c] ? 9'(xc) : 9'd0;
                end
                for (int r = 0; r < NR; r++) begin
                    oc     = q[0].ob + r;
                    eom[r] = (oc < od);
                    eo[r]  = eom[r] ? 8'(oc) : 8'd0;
                end
                chk("data_x",      64'(rq.data_req_x),      64'(ex));
                chk("data_mask",   64'(rq.data_req_mask),   64'(exm));
                chk("data_y",      64'(rq.data_req_y),      64'(q[0].y));
                chk("data_id",     64'(rq.data_req_id),     64'(q[0].id));
                chk("weight_od",   64'(rq.weight_req_od),   64'(eo));
                chk("weight_mask", 64'(rq.weight_req_mask), 64'(eom));
                chk("weight_id",   64'(rq.weight_req_id),   64'(q[0].id));
                if (!got_d && rq.data_req_ready)   got_d = 1;
                if (!got_w && rq.weight_req_ready) got_w = 1;
                if (got_d && got_w) begin
                    for (int c = 0; c < NC; c++)
                        exp_col[cyc + 1 + c] = (exp_col.exists(cyc + 1 + c) ? exp_col[cyc + 1 + c] : 4'd0) | (4'd1 << c);
                    for (int r = 0; r < NR; r++)
                        exp_row[cyc + 1 + r] = (exp_row.exists(cyc + 1 + r) ? exp_row[cyc + 1 + r] : 4'd0) | (4'd1 << r);
                    void'(q.pop_front());
                    got_d = 0;
                    got_w = 0;
                    if (q.size() == 0) t_done = cyc + NR + NC + 1;
                end
            end

            if (cyc == abort_cyc) begin
                reset = 1'b1;
                #1;
                check_all_zero("mid_reset");
                @(posedge clk);
                #1;
                reset = 1'b0;
                finished = 1;
                break;
            end
            if (t_done >= 0 && cyc == t_done + 1) begin
                finished = 1;
                break;
            end
        end
        cfg_start = 1'b0;
        chk("layer_end_reached", 64'(finished), 64'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset               = 1'b1;
        cfg_start           = 1'b0;
        cfg_img_h           = '0;
        cfg_img_w           = '0;
        cfg_od              = '0;
        cfg_id_m1           = '0;
        cfg_size_type       = 1'b0;
        rq.data_req_ready   = 1'b0;
        rq.weight_req_ready = 1'b0;

        #12;
        check_all_zero("reset");
        #1;
        reset = 1'b0;

        // Basic 8x8 layer, 3x3 kernels, both readys high.
        run_layer(8, 8, 4, 0, 1, 100, 0, -1, -1);
        // Partial OD group over two input channels.
        run_layer(8, 8, 6, 1, 1, 100, 0, -1, -1);
        // Data side stalled for three cycles while weights are accepted.
        run_layer(8, 8, 4, 0, 1, 100, 3, -1, -1);
        // Zero OD count, then a normal layer right after.
        run_layer(8, 8, 0, 0, 1, 100, 0, -1, -1);
        run_layer(12, 30, 5, 0, 0, 100, 0, -1, -1);
        // Start pulse while busy must be dropped.
        run_layer(8, 20, 4, 1, 1, 100, 0, 2, -1);
        // Reset during the third pass, then a clean restart.
        run_layer(8, 8, 6, 1, 1, 100, 0, -1, 3);
        run_layer(8, 8, 4, 0, 1, 100, 0, -1, -1);

        // Random layers under random backpressure.
        for (int k = 0; k < 8; k++) begin
            run_layer($urandom_range(0, 30), $urandom_range(1, 60), $urandom_range(1, 10),
                      $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(40, 100),
                      0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_array_scheduler.md
# pe_array_scheduler

Sequences a Winograd convolution layer over the N_ROW x N_COL PE array. It walks the tile, output-depth and input-channel loops, and issues data-tile requests to the input-transform stage and weight-tile requests to the weight-transform stage. After each matched request pair it fires systolically skewed launch strobes along the array edges. Data tiles enter the top of each column; weight tiles enter the left of each row.

## Interface
Parameters:
- N_ROW, 4, PE rows; each row receives one output-depth (OD) weight stream
- N_COL, 4, PE columns; each column receives one spatial data tile

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cfg_start  in  1  start a layer; ignored while busy
- cfg_img_h, cfg_img_w  in  9 each  image height / width, 0..511
- cfg_od  in  8  OD count, 0..128
- cfg_id_m1  in  4  input-channel count minus 1
- cfg_size_type  in  1  0: 1x1 kernel, stride 6; 1: 3x3 kernel, stride 4
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse at layer end
- data_req_valid / data_req_ready  out / in  1  data request handshake
- data_req_x  out  N_COL x 9  x index of each column tile
- data_req_y  out  9  y index shared by all columns
- data_req_id  out  4  input channel
- data_req_mask  out  N_COL  column c holds an in-image tile
- weight_req_valid / weight_req_ready  out / in  1  weight request handshake
- weight_req_od  out  N_ROW x 8  OD of each row
- weight_req_id  out  4  input channel
- weight_req_mask  out  N_ROW  row r holds a valid OD
- weight_size_type_o  out  1  latched cfg_size_type
- col_launch  out  N_COL  column c emits its data tile into the array
- row_launch  out  N_ROW  row r emits its weight tile into the array

## Operation
- **Config latch:** cfg_* is latched on an accepted cfg_start (start while IDLE). A start while busy is dropped.
- **Stride:** S = 6 when size_type is 0, S = 4 when size_type is 1.
- **Loop order, innermost first:**
  - id: 0..cfg_id_m1
  - od_base: 0, N_ROW, ... while od_base < cfg_od
  - x_base: 0, S*N_COL, ... while x_base < img_w
  - y: 0, S, ... while y < img_h
- **Request fields per pass:**
  - data_req_x[c] = x_base + c*S
  - data_req_mask[c] = (x_base + c*S < img_w)
  - weight_req_od[r] = od_base + r
  - weight_req_mask[r] = (od_base + r < cfg_od)
  - Masked-off lanes drive index 0.
- **Internal widths:** x/y compares are 10-bit, so x_base + c*S never wraps. od compares are 9-bit.
- **FSM:**
  - IDLE -> ISSUE on start with non-zero img_h, img_w, cfg_od.
  - IDLE -> DONE on start with any of those zero; no requests are issued.
  - ISSUE: both req_valid go high. Each valid drops independently once accepted, and request fields hold stable until both are accepted.
  - Pass completion cycle T = the cycle the later of the two is accepted.
  - If the pass was not the last, the counters advance and the next request is valid at T+1 (ISSUE continues). After the last pass, go to DRAIN.
  - DRAIN: count N_ROW+N_COL cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- **Launch skew:** every completed pass injects a token into two delay lines. col_launch[c] pulses at T+1+c and row_launch[r] pulses at T+1+r. Masked lanes still pulse; the transform stages send zero tiles there.
- **Reset:** any time, including mid-pass, returns to IDLE. Counters clear, skew lines clear, and a pending layer is abandoned without a done pulse.
- **Reset values:** all outputs are 0.

## Timing
- Start accepted at cycle 0 -> first req_valid at cycle 1.
- With both readys held high: one pass per cycle.
- Requests are registered outputs. The ready inputs are not combinationally fed to any output.
- done = T_last + N_ROW + N_COL + 1. busy is high from cycle 1 through the done cycle inclusive.
- Zero-size config: done at cycle 1, busy high only in cycle 1.

## Structure
- **Shared package winocnn_pkg:**
  - TILE_DIM = 6, STRIDE_1X1 = 6, STRIDE_3X3 = 4
  - IDX_W = 9, OD_W = 8, ID_W = 4
  - sched_state_t enum: IDLE, ISSUE, DRAIN, DONE
- **Sub-module launch_skew (parameter LANES):** one-bit token shift line, tap k = input delayed k+1 cycles. Instantiated once with N_COL lanes and once with N_ROW lanes.

## Test plan
Defaults N_ROW = N_COL = 4 unless stated.
- **Basic 8x8 layer:** 8x8 image, size_type 1, od 4, id_m1 0, readys high -> 2 passes; y = 0 then 4; x = {0,4,8,12}; mask 0011; od = {0,1,2,3}, mask 1111; done at T_last + 9.
- **Partial OD group:** od = 6, id_m1 = 1 -> pass sequence (id0,od0-3), (id1,od0-3), (id0,od4-5 mask 0011), (id1,od4-5 mask 0011).
- **Data backpressure:** data_req_ready low for 3 cycles, weight ready high -> weight_req_valid drops after 1 cycle; data fields stay stable; col_launch[0] pulses 1 cycle after the data accept; col_launch[3] 3 cycles later.
- **Zero config:** cfg_od = 0 -> no req_valid ever; done at cycle 1; second start afterward is accepted normally.
- **Reset mid-layer:** reset asserted during pass 3 -> all outputs 0 in the same cycle, including skew pulses. After a restart the first request is x=0, y=0, id=0, od=0.
- **Start while busy:** cfg_start pulsed mid-layer with a different cfg_img_w -> ignored; the pass count matches the original config.
